// File: rtl/pipe_pkg.sv
// Shared pipeline-stage constants: occupancy codes and bubble encoding.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Replicated across the payload width to form the default bubble.
  localparam logic PIPE_NOP = 1'b0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of a stage register: payload plus valid flag.
// Clear wins over load; a cleared slot holds the bubble value.
module pipe_entry_reg #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= NOP_VAL;
      vld <= 1'b0;
    end else if (clear) begin
      q   <= NOP_VAL;
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer,
// registered in_ready and synchronous flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP_VAL = {WIDTH{PIPE_NOP}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occ
);

  logic [1:0]       occ_q, occ_d;
  logic             ready_q, ready_d;
  logic             in_xfer, out_xfer;
  logic             main_load, main_clr;
  logic             skid_load, skid_clr;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             main_vld, skid_vld;

  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = main_vld & out_ready;

  always_comb begin
    occ_d     = occ_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = in_data;
    if (flush) begin
      occ_d    = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            occ_d     = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            occ_d    = OCC_EMPTY;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            occ_d     = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (out_xfer && skid_vld) begin
            main_load = 1'b1;
            main_d    = skid_q;
            skid_clr  = 1'b1;
            occ_d     = OCC_ONE;
          end
        end
        default: begin
          occ_d    = OCC_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      ready_q <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      ready_q <= ready_d;
    end
  end

  pipe_entry_reg #(
    .WIDTH   (WIDTH),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q),
    .vld   (main_vld)
  );

  pipe_entry_reg #(
    .WIDTH   (WIDTH),
    .NOP_VAL (NOP_VAL)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_data),
    .q     (skid_q),
    .vld   (skid_vld)
  );

  assign in_ready  = ready_q;
  assign out_valid = main_vld;
  assign out_data  = main_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: three widths share one stimulus stream and one queue model.
// Directed scenarios first, then random valid/ready/flush traffic.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, flush;
  logic [36:0] d37;

  logic        ir16, ov16, ir1, ov1, ir37, ov37;
  logic [15:0] od16;
  logic [0:0]  od1;
  logic [36:0] od37;
  logic [1:0]  oc16, oc1, oc37;

  int n_chk  = 0;
  int n_pass = 0;

  logic [36:0] q[$];
  bit          m_ready;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .in_data(d37[15:0]), .out_valid(ov16), .out_ready(out_ready),
    .out_data(od16), .flush(flush), .occ(oc16)
  );

  pipe_stage_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .in_data(d37[0:0]), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .flush(flush), .occ(oc1)
  );

  pipe_stage_reg #(.WIDTH(37)) dut37 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir37),
    .in_data(d37), .out_valid(ov37), .out_ready(out_ready),
    .out_data(od37), .flush(flush), .occ(oc37)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all();
    logic [36:0] e;
    logic        v;
    v = (q.size() != 0);
    e = v ? q[0] : 37'd0;
    check("occ16", 64'(oc16), 64'(q.size()));
    check("vld16", 64'(ov16), 64'(v));
    check("dat16", 64'(od16), 64'(e[15:0]));
    check("rdy16", 64'(ir16), 64'(m_ready));
    check("occ1",  64'(oc1),  64'(q.size()));
    check("vld1",  64'(ov1),  64'(v));
    check("dat1",  64'(od1),  64'(e[0]));
    check("rdy1",  64'(ir1),  64'(m_ready));
    check("occ37", 64'(oc37), 64'(q.size()));
    check("vld37", 64'(ov37), 64'(v));
    check("dat37", 64'(od37), 64'(e));
    check("rdy37", 64'(ir37), 64'(m_ready));
  endtask

  // Queue model: the stage is a FIFO of depth 2 whose ready flag
  // reflects the fill level left by the previous edge.
  task automatic model_edge(input bit iv, input logic [36:0] d,
                            input bit ordy, input bit fl);
    bit ix, ox;
    ix = iv && m_ready;
    ox = (q.size() != 0) && ordy;
    if (fl) q.delete();
    else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(d);
    end
    m_ready = (q.size() < 2);
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic cycle(input bit iv, input logic [36:0] d,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    d37       = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all();
    model_edge(iv, d, ordy, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          iv, ordy, fl, pend, r0;
    logic [36:0] d;
    int          pv, pr;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    flush = 1'b0; d37 = '0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_vld", 64'(ov16), 64'd0);
    check("rst_dat", 64'(od16), 64'd0);
    check("rst_rdy", 64'(ir16), 64'd1);
    check("rst_occ", 64'(oc16), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 37'(i), 1'b1, 1'b0);
      check("str_dat", 64'(od16), 64'(i));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Stall fill, then release
    cycle(1'b1, 37'hA1, 1'b0, 1'b0);
    cycle(1'b1, 37'hA2, 1'b0, 1'b0);
    check("fill_occ", 64'(oc16), 64'd2);
    check("fill_rdy", 64'(ir16), 64'd0);
    cycle(1'b1, 37'hA3, 1'b0, 1'b0);
    check("stall_dat", 64'(od16), 64'hA1);
    cycle(1'b1, 37'hA3, 1'b1, 1'b0);
    check("rel_dat", 64'(od16), 64'hA2);
    cycle(1'b1, 37'hA3, 1'b1, 1'b0);
    check("rel_dat3", 64'(od16), 64'hA3);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("rel_empty", 64'(ov16), 64'd0);

    // Flush at occ=2 with a valid input offered
    cycle(1'b1, 37'h11, 1'b0, 1'b0);
    cycle(1'b1, 37'h22, 1'b0, 1'b0);
    cycle(1'b1, 37'hBEEF, 1'b0, 1'b1);
    check("fl_occ", 64'(oc16), 64'd0);
    check("fl_dat", 64'(od16), 64'd0);
    check("fl_rdy", 64'(ir16), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("fl_nobeef", 64'(ov16), 64'd0);

    // Flush coinciding with a transfer out at occ=1
    cycle(1'b1, 37'h5A5A, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; #1;
    check("flo_vld", 64'(ov16), 64'd1);
    check("flo_dat", 64'(od16), 64'h5A5A);
    #0;
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("flo_after", 64'(ov16), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset at occ=2
    cycle(1'b1, 37'h31, 1'b0, 1'b0);
    cycle(1'b1, 37'h32, 1'b0, 1'b0);
    in_valid = 1'b0; flush = 1'b0;
    #2; rst = 1'b1; #1;
    check("arst_vld", 64'(ov16), 64'd0);
    check("arst_dat", 64'(od16), 64'd0);
    check("arst_rdy", 64'(ir16), 64'd1);
    check("arst_occ", 64'(oc16), 64'd0);
    q.delete(); m_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic, upstream holds an unaccepted payload
    pend = 1'b0; d = '0;
    for (int ph = 0; ph < 3; ph++) begin
      pv = (ph == 0) ? 80 : (ph == 1) ? 50 : 20;
      pr = (ph == 0) ? 30 : (ph == 1) ? 60 : 90;
      for (int n = 0; n < 1000; n++) begin
        if (!pend) begin
          iv = ($urandom_range(99) < pv);
          d  = {$urandom, $urandom};
        end
        ordy = ($urandom_range(99) < pr);
        fl   = ($urandom_range(99) < 4);
        r0   = m_ready;
        cycle(iv, d, ordy, fl);
        pend = iv && !r0 && !fl;
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
